if_id_queue: RTL and testbench



---
 rtl/if_id_queue.sv | 193 +++++++++++++++++++
 tb/tb_if_id_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// if_id_queue
//
// Fetch-to-decode decoupling queue. It is a circular buffer of DEPTH entries.
// Each entry holds a PC, an instruction and an exception type. Both sides use
// valid/ready handshakes. A fetch entry that carries a nonzero exception type
// sets exc_hold, which blocks further pushes. Older entries and the faulting
// entry still drain to decode. A flush, or a reset, discards every entry and
// releases the hold.
//
// Optional feature: define IFQ_STATS_EN to build the two performance counters.
// When it is undefined, stall_cnt_o and full_cnt_o are tied to 0.
//
// Parameters:
//   PC_W, INST_W, EXC_W : widths of the entry fields
//   DEPTH               : number of entries (power of two, >= 2)
//
// Ports:
//   clock_i      clock; all state changes on the rising edge
//   reset_i      synchronous active-high reset
//   flush_i      discard all entries and clear exc_hold
//   in_valid_i   fetch presents an entry
//   in_ready_o   queue accepts the entry this cycle (registers only)
//   in_pc_i / in_inst_i / in_exc_i   fetched entry (exc 0 = no exception)
//   out_valid_o  head entry valid
//   out_ready_i  decode consumes the head entry
//   out_pc_o / out_inst_o / out_exc_o  head entry, 0 when empty
//   count_o      current occupancy
//   stall_cnt_o  cycles with decode ready and the queue empty (stats build)
//   full_cnt_o   cycles with the queue full (stats build)
// -----------------------------------------------------------------------------
module if_id_queue #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [PC_W-1:0]          in_pc_i,
    input  logic [INST_W-1:0]        in_inst_i,
    input  logic [EXC_W-1:0]         in_exc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [PC_W-1:0]          out_pc_o,
    output logic [INST_W-1:0]        out_inst_o,
    output logic [EXC_W-1:0]         out_exc_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [31:0]              stall_cnt_o,
    output logic [31:0]              full_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Entry storage. Data is never reset; only the pointers and count decide
    // what is valid.
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [PC_W-1:0]   pc_mem_d   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [EXC_W-1:0]  exc_mem_q  [DEPTH];
    logic [EXC_W-1:0]  exc_mem_d  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              exc_hold_q, exc_hold_d;

    logic              push;
    logic              pop;
    logic              not_full;

    // in_ready_o comes only from registers. A full queue refuses a push even
    // when decode pops in the same cycle. This keeps out_ready_i off the fetch
    // side's timing path.
    assign not_full    = (count_q != DEPTH_C);
    assign in_ready_o  = not_full && !exc_hold_q;
    assign out_valid_o = (count_q != '0);

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    assign out_pc_o   = out_valid_o ? pc_mem_q[rd_ptr_q]   : '0;
    assign out_inst_o = out_valid_o ? inst_mem_q[rd_ptr_q] : '0;
    assign out_exc_o  = out_valid_o ? exc_mem_q[rd_ptr_q]  : '0;
    assign count_o    = count_q;

    // Storage write. A write during a flush cycle is harmless, because the
    // pointers are cleared and the slot counts as empty.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        exc_mem_d  = exc_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]   = in_pc_i;
            inst_mem_d[wr_ptr_q] = in_inst_i;
            exc_mem_d[wr_ptr_q]  = in_exc_i;
        end
    end

    always_ff @(posedge clock_i) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
        exc_mem_q  <= exc_mem_d;
    end

    // Control next state. Flush overrides push/pop. Reset is applied in the
    // register block and overrides both. Power-of-two DEPTH lets the pointers
    // wrap by natural overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        exc_hold_d = exc_hold_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            exc_hold_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            // Once a faulting entry is accepted, nothing younger may follow it.
            if (push && (in_exc_i != '0)) begin
                exc_hold_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            exc_hold_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            exc_hold_q <= exc_hold_d;
        end
    end

`ifdef IFQ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] full_cnt_q, full_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // The counters survive a flush. They measure behaviour over the whole run,
    // not per redirect.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        full_cnt_d  = full_cnt_q;
        if (out_ready_i && !out_valid_o) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (!not_full) begin
            full_cnt_d = sat_inc(full_cnt_q);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            full_cnt_q  <= full_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign full_cnt_o  = full_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign full_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
`timescale 1ns/1ps
module tb_if_id_queue;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;
    localparam int EXC_W  = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [PC_W-1:0]   in_pc_i;
    logic [INST_W-1:0] in_inst_i;
    logic [EXC_W-1:0]  in_exc_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [PC_W-1:0]   out_pc_o;
    logic [INST_W-1:0] out_inst_o;
    logic [EXC_W-1:0]  out_exc_o;
    logic [CNT_W-1:0]  count_o;
    logic [31:0]       stall_cnt_o;
    logic [31:0]       full_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    if_id_queue #(
        .PC_W(PC_W), .INST_W(INST_W), .EXC_W(EXC_W), .DEPTH(DEPTH)
    ) dut (
        .clock_i(clk),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i),
        .in_inst_i(in_inst_i),
        .in_exc_i(in_exc_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o),
        .out_inst_o(out_inst_o),
        .out_exc_o(out_exc_o),
        .count_o(count_o),
        .stall_cnt_o(stall_cnt_o),
        .full_cnt_o(full_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_empty(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, " out_pc"},    64'(out_pc_o),    64'd0);
        chk({tag, " out_inst"},  64'(out_inst_o),  64'd0);
        chk({tag, " out_exc"},   64'(out_exc_o),   64'd0);
        chk({tag, " count"},     64'(count_o),     64'd0);
    endtask

    initial begin
        logic [31:0] exp_stall;
        logic [31:0] exp_full;

        reset_i     = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_pc_i     = '0;
        in_inst_i   = '0;
        in_exc_i    = '0;
        out_ready_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;

        // Reset state
        check_empty("reset");
        chk("reset in_ready", 64'(in_ready_o),  64'd1);
        chk("reset stall",    64'(stall_cnt_o), 64'd0);
        chk("reset full",     64'(full_cnt_o),  64'd0);

        // Single push, then hold with out_ready low
        in_valid_i = 1'b1;
        in_pc_i    = 32'h1000;
        in_inst_i  = 32'h2401_0001;
        in_exc_i   = '0;
        tick();
        in_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("single out_valid", 64'(out_valid_o), 64'd1);
            chk("single out_pc",    64'(out_pc_o),    64'h1000);
            chk("single out_inst",  64'(out_inst_o),  64'h2401_0001);
            chk("single count",     64'(count_o),     64'd1);
            tick();
        end

        // Flush back to empty
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_empty("flush1");
        chk("flush1 in_ready", 64'(in_ready_o), 64'd1);

        // Five pushes into a 4-deep queue; the fifth is refused
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            in_pc_i    = 32'h1000 + 32'(4 * i);
            in_inst_i  = 32'(i + 16);
            chk("fill in_ready", 64'(in_ready_o), (i < 4) ? 64'd1 : 64'd0);
            tick();
        end
        in_valid_i = 1'b0;
        chk("full count",    64'(count_o),    64'd4);
        chk("full in_ready", 64'(in_ready_o), 64'd0);

        // Drain in order
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain out_valid", 64'(out_valid_o), 64'd1);
            chk("drain out_pc",    64'(out_pc_o),    64'h1000 + 64'(4 * i));
            chk("drain out_inst",  64'(out_inst_o),  64'(i + 16));
            tick();
        end
        out_ready_i = 1'b0;
        check_empty("drained");

        // Fill to two entries, then stream one in and one out for 10 cycles
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1;
            in_pc_i    = 32'h3000 + 32'(4 * i);
            in_inst_i  = 32'h100 + 32'(i);
            tick();
        end
        chk("stream pre count", 64'(count_o), 64'd2);
        out_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_pc_i   = 32'h3000 + 32'(4 * (c + 2));
            in_inst_i = 32'h100 + 32'(c + 2);
            chk("stream count",    64'(count_o),    64'd2);
            chk("stream out_pc",   64'(out_pc_o),   64'h3000 + 64'(4 * c));
            chk("stream out_inst", 64'(out_inst_o), 64'h100 + 64'(c));
            tick();
        end
        in_valid_i = 1'b0;
        for (int c = 10; c < 12; c++) begin
            chk("stream tail pc", 64'(out_pc_o), 64'h3000 + 64'(4 * c));
            tick();
        end
        out_ready_i = 1'b0;
        check_empty("stream end");

        // A faulting fetch blocks further pushes until a flush
        in_valid_i = 1'b1;
        in_pc_i    = 32'h2000;
        in_inst_i  = 32'hDEAD_0000;
        in_exc_i   = 32'h0000_000C;
        tick();
        in_pc_i  = 32'h2004;
        in_exc_i = '0;
        chk("exc in_ready",  64'(in_ready_o), 64'd0);
        chk("exc count",     64'(count_o),    64'd1);
        chk("exc out_pc",    64'(out_pc_o),   64'h2000);
        chk("exc out_exc",   64'(out_exc_o),  64'h0C);
        tick();
        chk("exc held count",    64'(count_o),    64'd1);
        chk("exc held in_ready", 64'(in_ready_o), 64'd0);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("exc drained valid",    64'(out_valid_o), 64'd0);
        chk("exc drained in_ready", 64'(in_ready_o),  64'd0);
        in_valid_i = 1'b0;
        flush_i    = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("exc flush in_ready", 64'(in_ready_o), 64'd1);
        check_empty("exc flush");

        // Flush wins over a simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_pc_i    = 32'h4000 + 32'(4 * i);
            in_inst_i  = 32'h200 + 32'(i);
            tick();
        end
        chk("pre-flush count", 64'(count_o), 64'd3);
        in_pc_i     = 32'h400C;
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        tick();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check_empty("flush+push+pop");
        chk("flush+push+pop in_ready", 64'(in_ready_o), 64'd1);

        // Statistics counters, from a fresh reset
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("stats reset stall", 64'(stall_cnt_o), 64'd0);
        chk("stats reset full",  64'(full_cnt_o),  64'd0);
        out_ready_i = 1'b1;
        for (int c = 0; c < 7; c++) tick();
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_pc_i    = 32'h5000 + 32'(4 * i);
            tick();
        end
        in_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) tick();
`ifdef IFQ_STATS_EN
        exp_stall = 32'd7;
        exp_full  = 32'd5;
`else
        exp_stall = 32'd0;
        exp_full  = 32'd0;
`endif
        chk("stats stall", 64'(stall_cnt_o), 64'(exp_stall));
        chk("stats full",  64'(full_cnt_o),  64'(exp_full));
        // One pop; the cycle of the pop is still a full cycle
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
`ifdef IFQ_STATS_EN
        exp_full = 32'd6;
`endif
        chk("stats pop count", 64'(count_o),    64'd3);
        chk("stats pop full",  64'(full_cnt_o), 64'(exp_full));
        // A flush with the queue not full leaves both counters untouched
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("stats flush stall", 64'(stall_cnt_o), 64'(exp_stall));
        chk("stats flush full",  64'(full_cnt_o),  64'(exp_full));
        chk("stats flush count", 64'(count_o),     64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
